// File: rtl/shared_divider_if.sv
// Request/result bundle for the two-port shared divider.
// Port-side operands and the common result bus live here.
interface shared_divider_if #(
    parameter int WIDTH = 16
);
    logic             start_0;
    logic [WIDTH-1:0] dividend_0;
    logic [WIDTH-1:0] divisor_0;
    logic             start_1;
    logic [WIDTH-1:0] dividend_1;
    logic [WIDTH-1:0] divisor_1;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             ready;
    logic             select;
    logic             dbz;

    modport master (
        output start_0, dividend_0, divisor_0,
        output start_1, dividend_1, divisor_1,
        input  quotient, remainder, busy, ready, select, dbz
    );

    modport slave (
        input  start_0, dividend_0, divisor_0,
        input  start_1, dividend_1, divisor_1,
        output quotient, remainder, busy, ready, select, dbz
    );
endinterface

// File: rtl/shared_divider.sv
// Restoring divider shared by two requesters with round-robin grant.
// One quotient bit per cycle; results held until the next completion.
module shared_divider #(
    parameter int WIDTH = 16
) (
    input logic            clk,
    input logic            rst,
    shared_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic             pend0_q, pend0_d;
    logic             pend1_q, pend1_d;
    logic             prio_q, prio_d;
    logic             sel_q, sel_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] qout_q, qout_d;
    logic [WIDTH-1:0] rout_q, rout_d;
    logic             dbz_q, dbz_d;
    logic             req0, req1;
    logic             gnt0, gnt1;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] sub;
    logic             fits;

    assign req0  = bus.start_0 | pend0_q;
    assign req1  = bus.start_1 | pend1_q;
    // Shift the next dividend bit into the widened partial remainder.
    assign trial = {rem_q, quo_q[WIDTH-1]};
    assign fits  = trial >= {1'b0, dvs_q};
    assign sub   = trial[WIDTH-1:0] - dvs_q;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            pend0_q <= 1'b0;
            pend1_q <= 1'b0;
            prio_q  <= 1'b0;
            sel_q   <= 1'b0;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qout_q  <= '0;
            rout_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend0_q <= pend0_d;
            pend1_q <= pend1_d;
            prio_q  <= prio_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            qout_q  <= qout_d;
            rout_q  <= rout_d;
            dbz_q   <= dbz_d;
        end
    end

    // Arbitration, FSM next state and one restoring step per CALC cycle.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        qout_d  = qout_q;
        rout_d  = rout_q;
        dbz_d   = dbz_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0 && (!req1 || !prio_q)) begin
                    gnt0 = 1'b1;
                end else if (req1) begin
                    gnt1 = 1'b1;
                end
                if (gnt0 || gnt1) begin
                    state_d = CALC;
                    sel_d   = gnt1;
                    prio_d  = ~gnt1;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = gnt1 ? bus.dividend_1 : bus.dividend_0;
                    dvs_d   = gnt1 ? bus.divisor_1 : bus.divisor_0;
                end
            end
            CALC: begin
                rem_d = fits ? sub : trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], fits};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    qout_d  = quo_d;
                    rout_d  = rem_d;
                    dbz_d   = (dvs_q == '0);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        pend0_d = (pend0_q | bus.start_0) & ~gnt0;
        pend1_d = (pend1_q | bus.start_1) & ~gnt1;
    end

    assign bus.quotient  = qout_q;
    assign bus.remainder = rout_q;
    assign bus.busy      = (state_q == CALC);
    assign bus.ready     = (state_q == DONE);
    assign bus.select    = sel_q;
    assign bus.dbz       = dbz_q;
endmodule
